// File: rtl/st7735_rx.sv
`default_nettype none
// ============================================================================
//  Module      : st7735_rx
//  Description : Panel-side receiver for the 4-wire ST7735 serial link.
//                Oversamples CS/SCK/MOSI/DC in the clk domain, reassembles
//                bytes MSB first, decodes CASET/RASET/RAMWR and emits one
//                (x, y, RGB565) strobe per received pixel.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    WIDTH        panel columns (column-window end resets to WIDTH-1)
//    HEIGHT       panel rows    (row-window end resets to HEIGHT-1)
//    SYNC_STAGES  synchronizer depth on each SPI input (2..3)
//  Ports
//    clk          system clock, at least 4x spi_clk
//    reset        synchronous, active-high reset
//    spi_cs       chip select, active low (asynchronous)
//    spi_clk      serial clock, MOSI sampled on rising edge
//    spi_mosi     serial data, MSB first
//    spi_dc       0 = command byte, 1 = data byte
//    cmd_valid    one-cycle pulse, cmd_byte valid
//    cmd_byte     last received command byte
//    frame_start  one-cycle pulse on RAMWR (0x2C)
//    pix_valid    one-cycle pulse, pix_x/pix_y/pix_color valid
//    pix_x        pixel column
//    pix_y        pixel row
//    pix_color    pixel colour RGB565 {R5,G6,B5}
//    err_abort    one-cycle pulse when CS deasserts mid-byte
//  Build option
//    ST7735_RX_CLIP_EN  when defined, pixels whose cursor lies outside
//                       WIDTH x HEIGHT advance the cursor without pix_valid
// ============================================================================
module st7735_rx #(
    parameter int WIDTH       = 160,
    parameter int HEIGHT      = 128,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        spi_cs,
    input  logic        spi_clk,
    input  logic        spi_mosi,
    input  logic        spi_dc,
    output logic        cmd_valid,
    output logic [7:0]  cmd_byte,
    output logic        frame_start,
    output logic        pix_valid,
    output logic [7:0]  pix_x,
    output logic [6:0]  pix_y,
    output logic [15:0] pix_color,
    output logic        err_abort
);

    localparam logic [7:0] c_CMD_CASET = 8'h2A;
    localparam logic [7:0] c_CMD_RASET = 8'h2B;
    localparam logic [7:0] c_CMD_RAMWR = 8'h2C;

    localparam logic [7:0] c_XE_RST = 8'(WIDTH - 1);
    localparam logic [6:0] c_YE_RST = 7'(HEIGHT - 1);

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_CASET  = 3'd1;
    localparam logic [2:0] c_ST_RASET  = 3'd2;
    localparam logic [2:0] c_ST_RAMWR  = 3'd3;
    localparam logic [2:0] c_ST_IGNORE = 3'd4;

    // ------------------------------------------------------------------
    // Input synchronizer. Each stage is a nibble {cs, sck, mosi, dc};
    // stage 0 is the pin flop in the low nibble. CS resets high so the
    // link looks idle while the chain refills after reset.
    // ------------------------------------------------------------------
    localparam int c_SW = SYNC_STAGES * 4;

    logic [c_SW-1:0] r_sync;
    logic [3:0]      w_last;
    logic            w_s_cs;
    logic            w_s_clk;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync <= {SYNC_STAGES{4'b1000}};
        end else begin
            r_sync <= {r_sync[c_SW-5:0], spi_cs, spi_clk, spi_mosi, spi_dc};
        end
    end

    assign w_last  = r_sync[c_SW-1 -: 4];
    assign w_s_cs  = w_last[3];
    assign w_s_clk = w_last[2];

    // Registered edge detect; MOSI, DC and CS are delayed alongside it so
    // the byte assembler sees all four signals from the same sample.
    logic r_clk_prev;
    logic r_rise;
    logic r_mosi_d;
    logic r_dc_d;
    logic r_cs_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_clk_prev <= 1'b0;
            r_rise     <= 1'b0;
            r_mosi_d   <= 1'b0;
            r_dc_d     <= 1'b0;
            r_cs_d     <= 1'b1;
        end else begin
            r_clk_prev <= w_s_clk;
            r_rise     <= w_s_clk & ~r_clk_prev & ~w_s_cs;
            r_mosi_d   <= w_last[1];
            r_dc_d     <= w_last[0];
            r_cs_d     <= w_s_cs;
        end
    end

    // ------------------------------------------------------------------
    // Byte assembly
    // ------------------------------------------------------------------
    logic [2:0] r_bit_cnt;
    logic [6:0] r_shift;
    logic       r_byte_valid;
    logic [7:0] r_byte;
    logic       r_byte_dc;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_bit_cnt    <= 3'd0;
            r_shift      <= 7'd0;
            r_byte_valid <= 1'b0;
            r_byte       <= 8'h00;
            r_byte_dc    <= 1'b0;
            err_abort    <= 1'b0;
        end else begin
            r_byte_valid <= 1'b0;
            err_abort    <= 1'b0;
            if (r_cs_d) begin
                // Deselect drops any partial byte; only a nonzero count
                // means a byte was actually cut short.
                if (r_bit_cnt != 3'd0) begin
                    err_abort <= 1'b1;
                end
                r_bit_cnt <= 3'd0;
                r_shift   <= 7'd0;
            end else if (r_rise) begin
                r_shift   <= {r_shift[5:0], r_mosi_d};
                r_bit_cnt <= r_bit_cnt + 3'd1;
                if (r_bit_cnt == 3'd7) begin
                    r_byte       <= {r_shift, r_mosi_d};
                    r_byte_dc    <= r_dc_d;
                    r_byte_valid <= 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Decoder FSM: state register
    // ------------------------------------------------------------------
    logic [2:0] r_state;
    logic [2:0] w_state_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    logic w_cmd;
    logic w_dat;

    assign w_cmd = r_byte_valid & ~r_byte_dc;
    assign w_dat = r_byte_valid &  r_byte_dc;

    // Next-state logic: only command bytes move the FSM.
    always_comb begin
        w_state_nxt = r_state;
        if (w_cmd) begin
            case (r_byte)
                c_CMD_CASET: w_state_nxt = c_ST_CASET;
                c_CMD_RASET: w_state_nxt = c_ST_RASET;
                c_CMD_RAMWR: w_state_nxt = c_ST_RAMWR;
                default:     w_state_nxt = c_ST_IGNORE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Decoder FSM: output / datapath-control decode
    // ------------------------------------------------------------------
    logic [2:0]  r_idx;     // data-byte index inside CASET/RASET, saturates at 4
    logic        r_phase;   // 1 = colour high byte pending
    logic [7:0]  r_hi;
    logic [7:0]  r_xs;
    logic [7:0]  r_xe;
    logic [6:0]  r_ys;
    logic [6:0]  r_ye;
    logic [7:0]  r_cx;
    logic [6:0]  r_cy;

    logic        w_win_dat;
    logic        w_set_xs;
    logic        w_set_xe;
    logic        w_set_ys;
    logic        w_set_ye;
    logic        w_hi_store;
    logic        w_pix_done;
    logic        w_clip;
    logic        w_frame;

    always_comb begin
        w_win_dat  = 1'b0;
        w_set_xs   = 1'b0;
        w_set_xe   = 1'b0;
        w_set_ys   = 1'b0;
        w_set_ye   = 1'b0;
        w_hi_store = 1'b0;
        w_pix_done = 1'b0;
        w_frame    = w_cmd && (r_byte == c_CMD_RAMWR);
        if (w_dat) begin
            case (r_state)
                c_ST_CASET: begin
                    w_win_dat = 1'b1;
                    w_set_xs  = (r_idx == 3'd1);
                    w_set_xe  = (r_idx == 3'd3);
                end
                c_ST_RASET: begin
                    w_win_dat = 1'b1;
                    w_set_ys  = (r_idx == 3'd1);
                    w_set_ye  = (r_idx == 3'd3);
                end
                c_ST_RAMWR: begin
                    w_hi_store = ~r_phase;
                    w_pix_done =  r_phase;
                end
                default: begin
                end
            endcase
        end
    end

`ifdef ST7735_RX_CLIP_EN
    assign w_clip = ({1'b0, r_cx} >= 9'(WIDTH)) || ({1'b0, r_cy} >= 8'(HEIGHT));
`else
    assign w_clip = 1'b0;
`endif

    // Cursor advance inside the window; a start above the end simply
    // counts up modulo 256 until it meets the end column.
    logic [7:0] w_cx_nxt;
    logic [6:0] w_cy_nxt;

    always_comb begin
        w_cx_nxt = r_cx + 8'd1;
        w_cy_nxt = r_cy;
        if (r_cx == r_xe) begin
            w_cx_nxt = r_xs;
            w_cy_nxt = (r_cy == r_ye) ? r_ys : r_cy + 7'd1;
        end
    end

    // ------------------------------------------------------------------
    // Registered outputs and decoder datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            cmd_valid   <= 1'b0;
            cmd_byte    <= 8'h00;
            frame_start <= 1'b0;
            pix_valid   <= 1'b0;
            pix_x       <= 8'd0;
            pix_y       <= 7'd0;
            pix_color   <= 16'h0000;
            r_idx       <= 3'd0;
            r_phase     <= 1'b0;
            r_hi        <= 8'h00;
            r_xs        <= 8'd0;
            r_xe        <= c_XE_RST;
            r_ys        <= 7'd0;
            r_ye        <= c_YE_RST;
            r_cx        <= 8'd0;
            r_cy        <= 7'd0;
        end else begin
            cmd_valid   <= 1'b0;
            frame_start <= 1'b0;
            pix_valid   <= 1'b0;

            if (w_cmd) begin
                cmd_valid <= 1'b1;
                cmd_byte  <= r_byte;
                r_idx     <= 3'd0;
                // Any command discards a half-received pixel.
                r_phase   <= 1'b0;
            end

            if (w_frame) begin
                frame_start <= 1'b1;
                r_cx        <= r_xs;
                r_cy        <= r_ys;
            end

            if (w_win_dat && (r_idx != 3'd4)) begin
                r_idx <= r_idx + 3'd1;
            end
            if (w_set_xs) r_xs <= r_byte;
            if (w_set_xe) r_xe <= r_byte;
            if (w_set_ys) r_ys <= r_byte[6:0];
            if (w_set_ye) r_ye <= r_byte[6:0];

            if (w_hi_store) begin
                r_hi    <= r_byte;
                r_phase <= 1'b1;
            end

            if (w_pix_done) begin
                r_phase <= 1'b0;
                r_cx    <= w_cx_nxt;
                r_cy    <= w_cy_nxt;
                if (!w_clip) begin
                    pix_valid <= 1'b1;
                    pix_x     <= r_cx;
                    pix_y     <= r_cy;
                    pix_color <= {r_hi, r_byte};
                end
            end
        end
    end

endmodule
`default_nettype wire
